// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the colour-byte UART receiver.
//   rx_state_t : receiver state encoding
//   half_bit() : start-bit mid-point count for a given clocks-per-bit value
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  // Count at which the middle of the start bit is reached, measured from the
  // cycle after the falling edge was seen on the synchronised line.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_colour_rx_if.sv
// ---------------------------------------------------------------------------
// uart_colour_rx_if
// Valid/ready byte stream between the UART receiver and its consumer.
//   o_Data  : received byte, meaningful only while o_Valid is 1
//   o_Valid : o_Data holds an unconsumed byte
//   i_Ready : consumer can accept a byte this cycle
// A transfer happens on every clock edge where o_Valid && i_Ready.
// master = byte producer (receiver), slave = byte consumer (driver glue).
// ---------------------------------------------------------------------------
interface uart_colour_rx_if;

  logic [7:0] o_Data;
  logic       o_Valid;
  logic       i_Ready;

  modport master (
    output o_Data,
    output o_Valid,
    input  i_Ready
  );

  modport slave (
    input  o_Data,
    input  o_Valid,
    output i_Ready
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output (two clocks of latency)
// RST_VAL sets the value both flops take in reset; use the idle level of the
// pin so that leaving reset never looks like an edge.
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_colour_rx.sv
// ---------------------------------------------------------------------------
// uart_colour_rx
// 8N1 UART receiver feeding a one-deep byte buffer with a valid/ready output.
// Sits in front of the WS2812 driver and supplies its colour byte.
//   i_Clock    : system clock (PLL output)
//   i_Rstn     : asynchronous active-low reset
//   i_Rx       : asynchronous serial input, idle high
//   stream     : byte output (o_Data / o_Valid / i_Ready), master side
//   o_Busy     : a frame is in progress (receiver not idle)
//   o_FrameErr : one-cycle pulse, stop bit sampled low (byte discarded)
//   o_Overrun  : one-cycle pulse, good byte dropped because buffer was full
// CLKS_PER_BIT must be at least 4.
// ---------------------------------------------------------------------------
module uart_colour_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 417
) (
  input  logic             i_Clock,
  input  logic             i_Rstn,
  input  logic             i_Rx,
  uart_colour_rx_if.master stream,
  output logic             o_Busy,
  output logic             o_FrameErr,
  output logic             o_Overrun
);

  localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sr;
  logic [7:0]       data;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             transfer;

  // Line synchroniser: resets to the idle level so reset release is not a
  // start bit.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rstn),
    .d     (i_Rx),
    .q     (rx_s)
  );

  assign transfer = valid && stream.i_Ready;

  // Receiver FSM and output buffer. The buffer lives in the same block
  // because a good stop bit and a consumer transfer can land on one edge.
  always_ff @(posedge i_Clock or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sr        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer took the byte; a load below overrides this.
      if (transfer) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              // Line went back high before mid-bit: glitch, not a frame.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            sr  <= {rx_s, sr[7:1]};
            cnt <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              // Re-arm straight away so a back-to-back start bit is caught.
              state <= IDLE;
              busy  <= 1'b0;
              if (!valid || transfer) begin
                data  <= sr;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // A held-low break must not retrigger START, so wait for idle.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stream.o_Data  = data;
  assign stream.o_Valid = valid;
  assign o_Busy         = busy;
  assign o_FrameErr     = frame_err;
  assign o_Overrun      = overrun;

endmodule

// File: tb/tb_uart_colour_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_colour_rx
// Bench for uart_colour_rx at CLKS_PER_BIT = 8 (HALF_BIT = 3).
// The serial line and the ready signal are described as one value per clock
// cycle. A reference model derives, from the frame timing rules, where each
// start/data/stop sample lands on that line and what the buffer must show on
// every cycle, then the line is played into the DUT and compared cycle by
// cycle. Directed scenarios are followed by randomised frames.
// Timing reference: if line[p] is the first low cycle of a frame, edge 1 is
// the edge that samples line[p], so edge N is observed in log slot p+N-1 and
// the synchronised sample used at edge N is line[p+N-3].
// ---------------------------------------------------------------------------
module tb_uart_colour_rx;

  localparam int CPB = 8;

  logic i_Clock = 1'b0;
  logic i_Rstn  = 1'b1;
  logic i_Rx    = 1'b1;
  logic o_Busy;
  logic o_FrameErr;
  logic o_Overrun;

  uart_colour_rx_if bus ();

  uart_colour_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Rstn     (i_Rstn),
    .i_Rx       (i_Rx),
    .stream     (bus),
    .o_Busy     (o_Busy),
    .o_FrameErr (o_FrameErr),
    .o_Overrun  (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus, consumed by play().
  logic line_q[$];
  bit   rdy_q[$];
  bit   rnd_ready = 1'b0;

  // Reference buffer state carried across plays.
  bit         mv = 1'b0;
  logic [7:0] md = 8'h00;

  // Observations from the latest play.
  logic       obs_valid[];
  logic [7:0] obs_data[];
  logic       obs_busy[];
  logic       obs_ferr[];
  logic       obs_ovr[];
  int         n_ferr;
  int         n_ovr;
  int         n_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_level(input logic v, input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      line_q.push_back(v);
      rdy_q.push_back(rnd_ready ? 1'($urandom_range(0, 1)) : r);
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input logic stop, input bit r);
    add_level(1'b0, CPB, r);
    for (int k = 0; k < 8; k++) add_level(b[k], CPB, r);
    add_level(stop, CPB, r);
  endtask

  task automatic play();
    int         n;
    int         p;
    int         pos;
    int         q;
    logic [7:0] b;
    bit         mvl;
    logic [7:0] mdt;
    bit         xfer;
    bit         e_busy[];
    bit         e_ferr[];
    bit         e_ovr[];
    bit         e_ld[];
    bit         e_valid[];
    logic [7:0] e_byte[];
    logic [7:0] e_data[];

    n       = line_q.size();
    e_busy  = new[n];
    e_ferr  = new[n];
    e_ovr   = new[n];
    e_ld    = new[n];
    e_valid = new[n];
    e_byte  = new[n];
    e_data  = new[n];

    // Frame timing: start sample edge 7, data bit k edge 15+8k, stop edge 79.
    pos = 0;
    while (pos < n) begin
      p = pos;
      while (p < n && line_q[p] !== 1'b0) p++;
      if (p + 80 >= n) break;
      if (line_q[p+4] === 1'b1) begin
        // False start: busy from edge 3 until the start sample at edge 7.
        for (int i = p + 2; i <= p + 5; i++) e_busy[i] = 1'b1;
        pos = p + 5;
      end else begin
        for (int k = 0; k < 8; k++) b[k] = line_q[p + 12 + 8 * k];
        for (int i = p + 2; i <= p + 77; i++) e_busy[i] = 1'b1;
        if (line_q[p+76] === 1'b1) begin
          e_ld[p+78]   = 1'b1;
          e_byte[p+78] = b;
          pos          = p + 77;
        end else begin
          e_ferr[p+78] = 1'b1;
          q = p + 77;
          while (q < n && line_q[q] !== 1'b1) q++;
          for (int i = p + 78; i <= q + 1 && i < n; i++) e_busy[i] = 1'b1;
          pos = q + 1;
        end
      end
    end

    // One-deep buffer with valid/ready handshake.
    mvl = mv;
    mdt = md;
    for (int j = 0; j < n; j++) begin
      xfer = mvl && rdy_q[j];
      if (e_ld[j]) begin
        if (!mvl || xfer) begin
          mvl = 1'b1;
          mdt = e_byte[j];
        end else begin
          e_ovr[j] = 1'b1;
        end
      end else if (xfer) begin
        mvl = 1'b0;
      end
      e_valid[j] = mvl;
      e_data[j]  = mdt;
    end
    mv = mvl;
    md = mdt;

    obs_valid = new[n];
    obs_data  = new[n];
    obs_busy  = new[n];
    obs_ferr  = new[n];
    obs_ovr   = new[n];
    n_ferr    = 0;
    n_ovr     = 0;
    n_load    = 0;
    for (int j = 0; j < n; j++) begin
      i_Rx        = line_q[j];
      bus.i_Ready = rdy_q[j];
      @(posedge i_Clock);
      #1;
      obs_valid[j] = bus.o_Valid;
      obs_data[j]  = bus.o_Data;
      obs_busy[j]  = o_Busy;
      obs_ferr[j]  = o_FrameErr;
      obs_ovr[j]   = o_Overrun;
      if (o_FrameErr === 1'b1) n_ferr++;
      if (o_Overrun === 1'b1) n_ovr++;
      if (e_ld[j]) n_load++;
      check($sformatf("valid@%0d", j), 32'(obs_valid[j]), 32'(e_valid[j]));
      check($sformatf("data@%0d", j), 32'(obs_data[j]), 32'(e_data[j]));
      check($sformatf("busy@%0d", j), 32'(obs_busy[j]), 32'(e_busy[j]));
      check($sformatf("frame_err@%0d", j), 32'(obs_ferr[j]), 32'(e_ferr[j]));
      check($sformatf("overrun@%0d", j), 32'(obs_ovr[j]), 32'(e_ovr[j]));
    end
    line_q.delete();
    rdy_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pa, pf, pg, ps, p1, p2, pr;

    // Reset state
    bus.i_Ready = 1'b0;
    #2 i_Rstn = 1'b0;
    @(posedge i_Clock);
    @(posedge i_Clock);
    #1;
    check("rst_data", 32'(bus.o_Data), 32'h00);
    check("rst_valid", 32'(bus.o_Valid), 32'h0);
    check("rst_busy", 32'(o_Busy), 32'h0);
    check("rst_ferr", 32'(o_FrameErr), 32'h0);
    check("rst_ovr", 32'(o_Overrun), 32'h0);
    i_Rstn = 1'b1;
    @(posedge i_Clock);
    #1;

    // Basic receive of 0xA5 with the consumer always ready
    add_level(1'b1, 10, 1'b1);
    pa = line_q.size();
    add_frame(8'hA5, 1'b1, 1'b1);
    add_level(1'b1, 100, 1'b1);
    play();
    check("basic_valid_e78", 32'(obs_valid[pa+77]), 32'h0);
    check("basic_valid_e79", 32'(obs_valid[pa+78]), 32'h1);
    check("basic_valid_e80", 32'(obs_valid[pa+79]), 32'h0);
    check("basic_data", 32'(obs_data[pa+78]), 32'hA5);
    check("basic_busy_e2", 32'(obs_busy[pa+1]), 32'h0);
    check("basic_busy_e3", 32'(obs_busy[pa+2]), 32'h1);
    check("basic_busy_e78", 32'(obs_busy[pa+77]), 32'h1);
    check("basic_busy_e79", 32'(obs_busy[pa+78]), 32'h0);

    // Framing error with a held-low break, then a good 0x3C
    add_level(1'b1, 10, 1'b1);
    pf = line_q.size();
    add_frame(8'h3C, 1'b0, 1'b1);
    add_level(1'b0, 40, 1'b1);
    add_level(1'b1, 20, 1'b1);
    pg = line_q.size();
    add_frame(8'h3C, 1'b1, 1'b1);
    add_level(1'b1, 100, 1'b1);
    play();
    check("ferr_pulse_e79", 32'(obs_ferr[pf+78]), 32'h1);
    check("ferr_count", 32'(n_ferr), 32'd1);
    check("ferr_no_valid", 32'(obs_valid[pf+78]), 32'h0);
    check("ferr_busy_break", 32'(obs_busy[pf+100]), 32'h1);
    check("after_ferr_valid", 32'(obs_valid[pg+78]), 32'h1);
    check("after_ferr_data", 32'(obs_data[pg+78]), 32'h3C);

    // False start: two-cycle low glitch
    add_level(1'b1, 10, 1'b1);
    ps = line_q.size();
    add_level(1'b0, 2, 1'b1);
    add_level(1'b1, 100, 1'b1);
    play();
    check("glitch_busy_e3", 32'(obs_busy[ps+2]), 32'h1);
    check("glitch_busy_e7", 32'(obs_busy[ps+6]), 32'h0);
    check("glitch_ferr_count", 32'(n_ferr), 32'd0);
    check("glitch_ovr_count", 32'(n_ovr), 32'd0);
    check("glitch_valid", 32'(obs_valid[ps+80]), 32'h0);

    // Overrun: consumer stalled across two back-to-back frames
    add_level(1'b1, 10, 1'b0);
    p1 = line_q.size();
    add_frame(8'h11, 1'b1, 1'b0);
    p2 = line_q.size();
    add_frame(8'h22, 1'b1, 1'b0);
    add_level(1'b1, 20, 1'b0);
    pr = line_q.size();
    add_level(1'b1, 100, 1'b1);
    play();
    check("ovr_first_valid", 32'(obs_valid[p1+78]), 32'h1);
    check("ovr_pulse", 32'(obs_ovr[p2+78]), 32'h1);
    check("ovr_count", 32'(n_ovr), 32'd1);
    check("ovr_data_kept", 32'(obs_data[p2+78]), 32'h11);
    check("ovr_valid_held", 32'(obs_valid[pr-1]), 32'h1);
    check("ovr_after_xfer", 32'(obs_valid[pr]), 32'h0);
    check("ovr_data_after", 32'(obs_data[pr]), 32'h11);

    // Transfer and load on the same edge
    add_level(1'b1, 10, 1'b0);
    p1 = line_q.size();
    add_frame(8'h11, 1'b1, 1'b0);
    p2 = line_q.size();
    add_frame(8'h22, 1'b1, 1'b0);
    add_level(1'b1, 100, 1'b0);
    rdy_q[p2+78] = 1'b1;
    play();
    check("simul_before_data", 32'(obs_data[p2+77]), 32'h11);
    check("simul_before_valid", 32'(obs_valid[p2+77]), 32'h1);
    check("simul_valid", 32'(obs_valid[p2+78]), 32'h1);
    check("simul_data", 32'(obs_data[p2+78]), 32'h22);
    check("simul_no_ovr", 32'(obs_ovr[p2+78]), 32'h0);
    check("simul_held", 32'(obs_valid[p2+90]), 32'h1);

    // Randomised frames, gaps, glitches, stop errors and ready patterns
    rnd_ready = 1'b1;
    add_level(1'b1, 10, 1'b0);
    for (int f = 0; f < 24; f++) begin
      logic [7:0] b;
      logic       st;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 5) != 0);
      gap = st ? $urandom_range(0, 12) : 12 + $urandom_range(0, 12);
      add_frame(b, st, 1'b0);
      add_level(1'b1, gap, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        add_level(1'b0, $urandom_range(1, 3), 1'b0);
        add_level(1'b1, 8, 1'b0);
      end
    end
    add_level(1'b1, 100, 1'b0);
    play();
    rnd_ready = 1'b0;

    // Reset during data bit 4 of 0xFF with a byte pending
    add_level(1'b1, 10, 1'b0);
    add_frame(8'h5A, 1'b1, 1'b0);
    add_level(1'b1, 100, 1'b0);
    play();
    bus.i_Ready = 1'b0;
    i_Rx = 1'b0;
    repeat (CPB) begin
      @(posedge i_Clock);
      #1;
    end
    i_Rx = 1'b1;
    repeat (4 * CPB + 4) begin
      @(posedge i_Clock);
      #1;
    end
    check("pre_rst_busy", 32'(o_Busy), 32'h1);
    check("pre_rst_valid", 32'(bus.o_Valid), 32'h1);
    #2 i_Rstn = 1'b0;
    #1;
    check("mid_rst_data", 32'(bus.o_Data), 32'h00);
    check("mid_rst_valid", 32'(bus.o_Valid), 32'h0);
    check("mid_rst_busy", 32'(o_Busy), 32'h0);
    check("mid_rst_ferr", 32'(o_FrameErr), 32'h0);
    check("mid_rst_ovr", 32'(o_Overrun), 32'h0);
    repeat (3) @(posedge i_Clock);
    #1;
    i_Rstn = 1'b1;
    mv = 1'b0;
    md = 8'h00;
    add_level(1'b1, 30, 1'b1);
    p1 = line_q.size();
    add_frame(8'h80, 1'b1, 1'b1);
    add_level(1'b1, 100, 1'b1);
    play();
    check("post_rst_idle_valid", 32'(obs_valid[p1-1]), 32'h0);
    check("post_rst_load_count", 32'(n_load), 32'd1);
    check("post_rst_valid", 32'(obs_valid[p1+78]), 32'h1);
    check("post_rst_data", 32'(obs_data[p1+78]), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
